// File: rtl/autotype_sequencer.sv
// Power-on key-script generator: plays a parameter-defined sequence of reset
// pulses and key presses into the computer core, merged with the board buttons.
module autotype_sequencer #(
  parameter int unsigned                   N_KEYS       = 4,
  parameter int unsigned                   N_STEPS      = 16,
  parameter int unsigned                   STEP_LOG2    = 22,
  parameter int unsigned                   HOLD_LOG2    = 21,
  parameter logic [N_STEPS*(N_KEYS+1)-1:0] SCRIPT       = '0,
  parameter bit                            AUTOSTART    = 1'b1,
  parameter bit                            LOOP         = 1'b0,
  parameter bit                            ABORT_ON_KEY = 1'b1,
  localparam int unsigned                  SW           = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              user_n_reset,
  input  logic [N_KEYS-1:0] user_keys,
  output logic              n_reset_out,
  output logic [N_KEYS-1:0] keys_out,
  output logic              busy,
  output logic [SW-1:0]     step_index
);

  localparam int unsigned EW       = N_KEYS + 1;
  localparam int unsigned CW       = (STEP_LOG2 > 0) ? STEP_LOG2 : 1;
  localparam bit          HOLD_ALL = (HOLD_LOG2 >= STEP_LOG2);

  if (HOLD_LOG2 > STEP_LOG2) begin : g_bad_hold
    $fatal(1, "autotype_sequencer: HOLD_LOG2 must not exceed STEP_LOG2");
  end
  if (N_STEPS < 1) begin : g_bad_steps
    $fatal(1, "autotype_sequencer: N_STEPS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam state_t RST_STATE = AUTOSTART ? S_RUN : S_IDLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [SW-1:0]     r_step;
  logic [SW-1:0]     w_step_nxt;
  logic              r_n_reset_out;
  logic [N_KEYS-1:0] r_keys_out;
  logic              r_busy;

  logic [EW-1:0]     w_entry;
  logic              w_last_cyc;
  logic              w_last_step;
  logic              w_hold;
  logic              w_user_abort;
  logic              w_script_rst;
  logic [N_KEYS-1:0] w_script_key;
  logic              w_n_reset_nxt;
  logic [N_KEYS-1:0] w_keys_nxt;
  logic              w_busy_nxt;

  assign w_last_cyc   = (STEP_LOG2 == 0) ? 1'b1 : (&r_cnt);
  assign w_last_step  = (r_step == SW'(N_STEPS - 1));
  assign w_hold       = HOLD_ALL ? 1'b1 : ((r_cnt >> HOLD_LOG2) == '0);
  assign w_user_abort = ABORT_ON_KEY && (|user_keys);

  // Script entry for the current step
  always_comb begin
    w_entry = '0;
    for (int i = 0; i < int'(N_STEPS); i++) begin
      if (r_step == SW'(i)) w_entry = SCRIPT[i*EW +: EW];
    end
  end

  // State, step and cycle counter registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next-state logic; start overrides abort and user keys in every state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    if (start) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_step_nxt  = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (abort || w_user_abort) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_last_cyc) begin
              w_cnt_nxt = '0;
              if (!w_last_step) begin
                w_step_nxt = r_step + SW'(1);
              end else if (LOOP) begin
                w_step_nxt = '0;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        S_IDLE, S_DONE: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_step_nxt  = '0;
        end
      endcase
    end
  end

  // Script drive and merge with the physical buttons
  always_comb begin
    w_script_rst  = 1'b0;
    w_script_key  = '0;
    if (r_state == S_RUN) begin
      w_script_rst = w_entry[0];
      if (w_hold) w_script_key = w_entry[EW-1:1];
    end
    w_n_reset_nxt = user_n_reset & ~w_script_rst;
    w_keys_nxt    = user_keys | w_script_key;
    w_busy_nxt    = (w_state_nxt == S_RUN);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_n_reset_out <= 1'b0;
      r_keys_out    <= '0;
      r_busy        <= AUTOSTART;
    end else begin
      r_n_reset_out <= w_n_reset_nxt;
      r_keys_out    <= w_keys_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign n_reset_out = r_n_reset_out;
  assign keys_out    = r_keys_out;
  assign busy        = r_busy;
  assign step_index  = r_step;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Directed bench for autotype_sequencer: one-shot, looping, abort, restart,
// mid-step reset and manual-start instances sharing one clock.
module tb_autotype_sequencer;

  localparam int unsigned NK = 3;
  localparam logic [15:0] SCR = 16'h8021;

  logic clk;
  int   n_checks;
  int   n_fail;

  // instance A: one-shot, autostart; B: looping; C: manual start
  logic          rst_a, start_a, abort_a, unr_a, nro_a, busy_a;
  logic [NK-1:0] ukeys_a, ko_a;
  logic [1:0]    step_a;
  logic          rst_b, start_b, abort_b, unr_b, nro_b, busy_b;
  logic [NK-1:0] ukeys_b, ko_b;
  logic [1:0]    step_b;
  logic          rst_c, start_c, abort_c, unr_c, nro_c, busy_c;
  logic [NK-1:0] ukeys_c, ko_c;
  logic [1:0]    step_c;

  autotype_sequencer #(.N_KEYS(NK), .N_STEPS(4), .STEP_LOG2(3), .HOLD_LOG2(2),
    .SCRIPT(SCR), .AUTOSTART(1'b1), .LOOP(1'b0), .ABORT_ON_KEY(1'b1)) u_dut_a (
    .clk(clk), .n_reset(rst_a), .start(start_a), .abort(abort_a),
    .user_n_reset(unr_a), .user_keys(ukeys_a), .n_reset_out(nro_a),
    .keys_out(ko_a), .busy(busy_a), .step_index(step_a));

  autotype_sequencer #(.N_KEYS(NK), .N_STEPS(4), .STEP_LOG2(3), .HOLD_LOG2(2),
    .SCRIPT(SCR), .AUTOSTART(1'b1), .LOOP(1'b1), .ABORT_ON_KEY(1'b1)) u_dut_b (
    .clk(clk), .n_reset(rst_b), .start(start_b), .abort(abort_b),
    .user_n_reset(unr_b), .user_keys(ukeys_b), .n_reset_out(nro_b),
    .keys_out(ko_b), .busy(busy_b), .step_index(step_b));

  autotype_sequencer #(.N_KEYS(NK), .N_STEPS(4), .STEP_LOG2(3), .HOLD_LOG2(2),
    .SCRIPT(SCR), .AUTOSTART(1'b0), .LOOP(1'b0), .ABORT_ON_KEY(1'b1)) u_dut_c (
    .clk(clk), .n_reset(rst_c), .start(start_c), .abort(abort_c),
    .user_n_reset(unr_c), .user_keys(ukeys_c), .n_reset_out(nro_c),
    .keys_out(ko_c), .busy(busy_c), .step_index(step_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected playback for SCRIPT=16'h8021, 8-cycle steps, 4-cycle hold;
  // c counts output cycles after the edge that entered RUN at step 0.
  function automatic logic exp_nrst(input int c, input bit lp);
    int p;
    p = ((c - 1) % 32) + 1;
    if (!lp && c > 32) return 1'b1;
    return (p <= 8) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [2:0] exp_keys(input int c, input bit lp);
    int p;
    p = ((c - 1) % 32) + 1;
    if (!lp && c > 32) return 3'b000;
    if (p >= 9 && p <= 12) return 3'b001;
    if (p >= 25 && p <= 28) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic exp_busy(input int c, input bit lp);
    return lp ? 1'b1 : ((c < 32) ? 1'b1 : 1'b0);
  endfunction

  function automatic logic [1:0] exp_step(input int c, input bit lp);
    if (lp) return 2'((c / 8) % 4);
    return (c >= 32) ? 2'd3 : 2'(c / 8);
  endfunction

  task automatic chk_cycle(input string tag, input int c, input bit lp, input logic nro,
                           input logic [2:0] ko, input logic bsy, input logic [1:0] stp);
    check($sformatf("%s c%0d n_reset_out", tag, c), 32'(nro), 32'(exp_nrst(c, lp)));
    check($sformatf("%s c%0d keys_out", tag, c), 32'(ko), 32'(exp_keys(c, lp)));
    check($sformatf("%s c%0d busy", tag, c), 32'(bsy), 32'(exp_busy(c, lp)));
    check($sformatf("%s c%0d step_index", tag, c), 32'(stp), 32'(exp_step(c, lp)));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; unr_a = 1'b1; ukeys_a = '0;
    rst_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; unr_b = 1'b1; ukeys_b = '0;
    rst_c = 1'b0; start_c = 1'b0; abort_c = 1'b0; unr_c = 1'b1; ukeys_c = '0;
    tick(2);

    // reset values
    check("rstA n_reset_out", 32'(nro_a), 32'd0);
    check("rstA keys_out", 32'(ko_a), 32'd0);
    check("rstA step_index", 32'(step_a), 32'd0);
    check("rstA busy", 32'(busy_a), 32'd1);
    check("rstC busy", 32'(busy_c), 32'd0);
    check("rstC n_reset_out", 32'(nro_c), 32'd0);

    // one-shot playback
    rst_a = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick(1);
      chk_cycle("oneshot", c, 1'b0, nro_a, ko_a, busy_a, step_a);
    end

    // looping playback
    rst_b = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      tick(1);
      chk_cycle("loop", c, 1'b1, nro_b, ko_b, busy_b, step_b);
    end

    // user key aborts playback during step 1
    rst_a = 1'b0;
    tick(2);
    rst_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      chk_cycle("pre_abort", c, 1'b0, nro_a, ko_a, busy_a, step_a);
    end
    ukeys_a = 3'b010;
    tick(1);
    check("abort keys_out", 32'(ko_a), 32'h2);
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort step_index", 32'(step_a), 32'd1);
    check("abort n_reset_out", 32'(nro_a), 32'd1);
    tick(1);
    check("done keys_out", 32'(ko_a), 32'h2);
    check("done busy", 32'(busy_a), 32'd0);
    ukeys_a = '0;
    tick(1);
    check("done idle keys_out", 32'(ko_a), 32'h0);

    // start beats simultaneous abort in DONE
    start_a = 1'b1;
    abort_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("restart busy", 32'(busy_a), 32'd1);
    check("restart step_index", 32'(step_a), 32'd0);
    check("restart n_reset_out", 32'(nro_a), 32'd1);
    tick(1);
    check("restart+1 n_reset_out", 32'(nro_a), 32'd0);
    check("restart+1 busy", 32'(busy_a), 32'd1);
    tick(9);
    check("restart+10 step_index", 32'(step_a), 32'd1);
    check("restart+10 keys_out", 32'(ko_a), 32'h1);
    check("restart+10 n_reset_out", 32'(nro_a), 32'd1);

    // start while RUN restarts from step 0
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("rerun step_index", 32'(step_a), 32'd0);
    check("rerun busy", 32'(busy_a), 32'd1);
    tick(1);
    check("rerun+1 n_reset_out", 32'(nro_a), 32'd0);
    check("rerun+1 keys_out", 32'(ko_a), 32'h0);
    tick(19);
    check("rerun+20 step_index", 32'(step_a), 32'd2);

    // asynchronous reset mid-step
    rst_a = 1'b0;
    #1;
    check("midrst n_reset_out", 32'(nro_a), 32'd0);
    check("midrst keys_out", 32'(ko_a), 32'd0);
    check("midrst step_index", 32'(step_a), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd1);
    tick(3);
    rst_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      chk_cycle("after_rst", c, 1'b0, nro_a, ko_a, busy_a, step_a);
    end

    // manual start: idle pass-through, then playback on start
    rst_c = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      logic drv;
      drv = (c >= 50 && c < 53) ? 1'b0 : 1'b1;
      unr_c = drv;
      tick(1);
      check($sformatf("idle c%0d n_reset_out", c), 32'(nro_c), 32'(drv));
      check($sformatf("idle c%0d busy", c), 32'(busy_c), 32'd0);
      check($sformatf("idle c%0d keys_out", c), 32'(ko_c), 32'd0);
    end
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    check("startC busy", 32'(busy_c), 32'd1);
    check("startC step_index", 32'(step_c), 32'd0);
    for (int c = 1; c <= 34; c++) begin
      tick(1);
      chk_cycle("manual", c, 1'b0, nro_c, ko_c, busy_c, step_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
